// File: rtl/wb_port_arb.sv
// Write-back port arbiter: merges MEM pipe results and buffered divider results onto one RF write port.
// Optional WB_ARB_BYPASS_EN lets a divider result skip the FIFO when the port is otherwise idle.
module wb_port_arb #(
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        pipe_valid,
  output logic        pipe_allowin,
  input  logic [69:0] pipe_bus,
  input  logic        div_valid,
  output logic        div_ready,
  input  logic [68:0] div_bus,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic [37:0] wb_to_id_bus,
  output logic [31:0] debug_wb_pc,
  output logic [3:0]  debug_wb_rf_we,
  output logic [4:0]  debug_wb_rf_wnum,
  output logic [31:0] debug_wb_rf_wdata
);

  localparam logic [3:0] SMAX = 4'(STARVE_MAX);

  logic [68:0] mem_q [2];
  logic [68:0] mem_d [2];
  logic        wr_ptr_q, wr_ptr_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [3:0]  scnt_q, scnt_d;
  logic        out_valid_q, out_valid_d;
  logic        out_we_q, out_we_d;
  logic [4:0]  out_waddr_q, out_waddr_d;
  logic [31:0] out_wdata_q, out_wdata_d;
  logic [31:0] out_pc_q, out_pc_d;

  logic fifo_ne, force_drain, pipe_grant, fifo_grant, div_push, bypass, enq;

  assign fifo_ne      = (cnt_q != 2'd0);
  assign force_drain  = fifo_ne & (scnt_q == SMAX);
  assign pipe_allowin = ~force_drain;
  assign div_ready    = (cnt_q < 2'd2);
  assign pipe_grant   = pipe_valid & pipe_allowin;
  assign fifo_grant   = ~pipe_grant & fifo_ne;
  assign div_push     = div_valid & div_ready;
`ifdef WB_ARB_BYPASS_EN
  assign bypass       = div_push & ~fifo_ne & ~pipe_grant;
`else
  assign bypass       = 1'b0;
`endif
  assign enq          = div_push & ~bypass;

  always_comb begin
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    cnt_d       = cnt_q;
    scnt_d      = 4'd0;
    out_valid_d = pipe_grant | fifo_grant | bypass;
    out_we_d    = out_we_q;
    out_waddr_d = out_waddr_q;
    out_wdata_d = out_wdata_q;
    out_pc_d    = out_pc_q;

    if (enq) begin
      mem_d[wr_ptr_q] = div_bus;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (fifo_grant) rd_ptr_d = ~rd_ptr_q;

    case ({enq, fifo_grant})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase

    // Count pipe wins only while a divider result is actually waiting.
    if (pipe_grant && fifo_ne) scnt_d = (scnt_q == SMAX) ? SMAX : scnt_q + 4'd1;

    if (pipe_grant) begin
      {out_we_d, out_waddr_d, out_wdata_d, out_pc_d} = pipe_bus;
    end else if (fifo_grant) begin
      out_we_d = 1'b1;
      {out_waddr_d, out_wdata_d, out_pc_d} = mem_q[rd_ptr_q];
    end else if (bypass) begin
      out_we_d = 1'b1;
      {out_waddr_d, out_wdata_d, out_pc_d} = div_bus;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_q[0]    <= '0;
      mem_q[1]    <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      cnt_q       <= 2'd0;
      scnt_q      <= 4'd0;
      out_valid_q <= 1'b0;
      out_we_q    <= 1'b0;
      out_waddr_q <= '0;
      out_wdata_q <= '0;
      out_pc_q    <= '0;
    end else begin
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      scnt_q      <= scnt_d;
      out_valid_q <= out_valid_d;
      out_we_q    <= out_we_d;
      out_waddr_q <= out_waddr_d;
      out_wdata_q <= out_wdata_d;
      out_pc_q    <= out_pc_d;
    end
  end

  assign rf_we             = out_valid_q & out_we_q;
  assign rf_waddr          = out_waddr_q;
  assign rf_wdata          = out_wdata_q;
  assign wb_to_id_bus      = {rf_we, out_waddr_q, out_wdata_q};
  assign debug_wb_pc       = out_pc_q;
  assign debug_wb_rf_we    = {4{rf_we}};
  assign debug_wb_rf_wnum  = out_waddr_q;
  assign debug_wb_rf_wdata = out_wdata_q;

endmodule

// File: tb/tb_wb_port_arb.sv
// Scoreboard bench for wb_port_arb: stimulus queues expected RF writes, a negedge monitor checks them.
module tb_wb_port_arb;

`ifdef WB_ARB_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        resetn;
  logic        pipe_valid, div_valid;
  logic        pipe_allowin, div_ready;
  logic [69:0] pipe_bus;
  logic [68:0] div_bus;
  logic        rf_we;
  logic [4:0]  rf_waddr, debug_wb_rf_wnum;
  logic [31:0] rf_wdata, debug_wb_pc, debug_wb_rf_wdata;
  logic [37:0] wb_to_id_bus;
  logic [3:0]  debug_wb_rf_we;

  wb_port_arb #(.STARVE_MAX(3)) dut (
    .clk(clk), .resetn(resetn),
    .pipe_valid(pipe_valid), .pipe_allowin(pipe_allowin), .pipe_bus(pipe_bus),
    .div_valid(div_valid), .div_ready(div_ready), .div_bus(div_bus),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .wb_to_id_bus(wb_to_id_bus),
    .debug_wb_pc(debug_wb_pc), .debug_wb_rf_we(debug_wb_rf_we),
    .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  int total = 0;
  int bad = 0;

  typedef struct packed {
    int          c;
    logic [4:0]  a;
    logic [31:0] d;
    logic [31:0] pc;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;

  function automatic logic [31:0] dat(input logic [4:0] a);
    return 32'h5000_0000 + {27'b0, a};
  endfunction

  function automatic logic [31:0] pcf(input logic [4:0] a);
    return 32'h1c00_1000 + {25'b0, a, 2'b00};
  endfunction

  task automatic chk(input string nm, input logic [69:0] act, input logic [69:0] req);
    total = total + 1;
    if (act !== req) begin
      bad = bad + 1;
      $display("FAIL %s: got %0h required %0h (cyc %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic exp_w(input int c, input logic [4:0] a, input logic [31:0] d, input logic [31:0] pc);
    exp_t e;
    e.c = c; e.a = a; e.d = d; e.pc = pc;
    sbq.push_back(e);
  endtask

  task automatic drv_pipe(input logic v, input logic we, input logic [4:0] a,
                          input logic [31:0] d, input logic [31:0] pc);
    pipe_valid = v;
    pipe_bus   = {we, a, d, pc};
  endtask

  task automatic drv_div(input logic v, input logic [4:0] a, input logic [31:0] d, input logic [31:0] pc);
    div_valid = v;
    div_bus   = {a, d, pc};
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Monitor: every RF write must match the queue head, in order and at the expected cycle.
  always @(negedge clk) begin
    if (resetn === 1'b1 && rf_we === 1'b1) begin
      total = total + 1;
      if (sbq.size() == 0) begin
        bad = bad + 1;
        $display("FAIL unexpected_write: got waddr=%0d wdata=%h pc=%h at cyc %0d, required no write",
                 rf_waddr, rf_wdata, debug_wb_pc, cyc);
      end else begin
        mon_e = sbq.pop_front();
        if ({cyc, rf_waddr, rf_wdata, debug_wb_pc} !== {mon_e.c, mon_e.a, mon_e.d, mon_e.pc}) begin
          bad = bad + 1;
          $display("FAIL wb_write: got cyc=%0d waddr=%0d wdata=%h pc=%h required cyc=%0d waddr=%0d wdata=%h pc=%h",
                   cyc, rf_waddr, rf_wdata, debug_wb_pc, mon_e.c, mon_e.a, mon_e.d, mon_e.pc);
        end
        total = total + 1;
        if ({debug_wb_rf_we, debug_wb_rf_wnum, debug_wb_rf_wdata, wb_to_id_bus} !==
            {4'hf, mon_e.a, mon_e.d, 1'b1, mon_e.a, mon_e.d}) begin
          bad = bad + 1;
          $display("FAIL wb_mirror: got dbg_we=%h wnum=%0d wdata=%h id_bus=%h required waddr=%0d wdata=%h",
                   debug_wb_rf_we, debug_wb_rf_wnum, debug_wb_rf_wdata, wb_to_id_bus, mon_e.a, mon_e.d);
        end
      end
    end
    if (sbq.size() > 0 && sbq[0].c < cyc) begin
      total = total + 1;
      bad = bad + 1;
      $display("FAIL missing_write: got no write for waddr=%0d by cyc %0d, required at cyc %0d",
               sbq[0].a, cyc, sbq[0].c);
      void'(sbq.pop_front());
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  bit rdy_e [9] = '{1, 1, 0, 0, 0, 1, 0, 0, 1};
  bit alw_e [9] = '{1, 1, 1, 1, 0, 1, 1, 1, 1};

  initial begin
    int c, k, pk, dk;
    logic pacc, dacc;
    resetn = 1'b0;
    drv_pipe(0, 0, 0, 0, 0);
    drv_div(0, 0, 0, 0);

    #3;
    chk("rst_rf_we", rf_we, 0);
    chk("rst_dbg_we", debug_wb_rf_we, 0);
    chk("rst_allowin", pipe_allowin, 1);
    chk("rst_div_ready", div_ready, 1);
    chk("rst_id_bus", wb_to_id_bus, 0);
    chk("rst_pc", debug_wb_pc, 0);
    tick(); tick();
    resetn = 1'b1;

    // Single pipe write, one-cycle latency.
    exp_w(cyc + 1, 5'd3, 32'h1234, 32'h1c000000);
    drv_pipe(1, 1, 5'd3, 32'h1234, 32'h1c000000);
    tick();
    drv_pipe(0, 0, 0, 0, 0);
    chk("pipe_rf_we", rf_we, 1);
    chk("pipe_waddr", rf_waddr, 3);
    chk("pipe_wdata", rf_wdata, 32'h1234);
    chk("pipe_pc", debug_wb_pc, 32'h1c000000);
    tick();

    // Single divider write with the pipe idle.
    exp_w(cyc + LAT, 5'd7, 32'hdead, 32'h1c000004);
    drv_div(1, 5'd7, 32'hdead, 32'h1c000004);
    tick();
    drv_div(0, 0, 0, 0);
    chk("div_lat_first_cycle", rf_we, (LAT == 1) ? 1 : 0);
    tick(); tick(); tick();

    // Pipe entry without write enable.
    drv_pipe(1, 0, 5'd9, 32'h9999, 32'h1c000008);
    tick();
    drv_pipe(0, 0, 0, 0, 0);
    chk("nowe_rf_we", rf_we, 0);
    chk("nowe_dbg_we", debug_wb_rf_we, 4'b0000);
    chk("nowe_pc", debug_wb_pc, 32'h1c000008);
    chk("nowe_wnum", debug_wb_rf_wnum, 9);
    tick();

    // Starvation limit: three pipe wins, one forced divider slot, then the pipe again.
    c = cyc;
    exp_w(c + 1, 5'd10, dat(5'd10), pcf(5'd10));
    exp_w(c + 2, 5'd11, dat(5'd11), pcf(5'd11));
    exp_w(c + 3, 5'd12, dat(5'd12), pcf(5'd12));
    exp_w(c + 4, 5'd13, dat(5'd13), pcf(5'd13));
    exp_w(c + 5, 5'd20, dat(5'd20), pcf(5'd20));
    exp_w(c + 6, 5'd14, dat(5'd14), pcf(5'd14));
    k = 0;
    for (int i = 0; i < 6; i++) begin
      chk("starve_allowin", pipe_allowin, (i != 4) ? 1 : 0);
      drv_pipe(1, 1, 5'(10 + k), dat(5'(10 + k)), pcf(5'(10 + k)));
      drv_div(i == 0, 5'd20, dat(5'd20), pcf(5'd20));
      pacc = pipe_allowin;
      tick();
      if (pacc) k = k + 1;
    end
    drv_pipe(0, 0, 0, 0, 0);
    drv_div(0, 0, 0, 0);
    tick(); tick();

    // Three divider pulses against a saturating pipe; FIFO fills and back-pressures.
    c = cyc;
    exp_w(c + 1, 5'd1, dat(5'd1), pcf(5'd1));
    exp_w(c + 2, 5'd2, dat(5'd2), pcf(5'd2));
    exp_w(c + 3, 5'd3, dat(5'd3), pcf(5'd3));
    exp_w(c + 4, 5'd4, dat(5'd4), pcf(5'd4));
    exp_w(c + 5, 5'd21, dat(5'd21), pcf(5'd21));
    exp_w(c + 6, 5'd5, dat(5'd5), pcf(5'd5));
    exp_w(c + 7, 5'd6, dat(5'd6), pcf(5'd6));
    exp_w(c + 8, 5'd22, dat(5'd22), pcf(5'd22));
    exp_w(c + 9, 5'd23, dat(5'd23), pcf(5'd23));
    pk = 0;
    dk = 0;
    for (int i = 0; i < 9; i++) begin
      chk("sat_div_ready", div_ready, rdy_e[i]);
      chk("sat_allowin", pipe_allowin, alw_e[i]);
      drv_pipe(pk < 6, 1, 5'(1 + pk), dat(5'(1 + pk)), pcf(5'(1 + pk)));
      drv_div(dk < 3, 5'(21 + dk), dat(5'(21 + dk)), pcf(5'(21 + dk)));
      pacc = (pk < 6) && pipe_allowin;
      dacc = (dk < 3) && div_ready;
      tick();
      if (pacc) pk = pk + 1;
      if (dacc) dk = dk + 1;
    end
    drv_pipe(0, 0, 0, 0, 0);
    drv_div(0, 0, 0, 0);
    tick(); tick();

    // Fill the FIFO, then reset asynchronously mid-cycle; nothing buffered may surface.
    c = cyc;
    exp_w(c + 1, 5'd24, dat(5'd24), pcf(5'd24));
    exp_w(c + 2, 5'd25, dat(5'd25), pcf(5'd25));
    drv_pipe(1, 1, 5'd24, dat(5'd24), pcf(5'd24));
    drv_div(1, 5'd26, dat(5'd26), pcf(5'd26));
    tick();
    drv_pipe(1, 1, 5'd25, dat(5'd25), pcf(5'd25));
    drv_div(1, 5'd27, dat(5'd27), pcf(5'd27));
    tick();
    drv_pipe(0, 0, 0, 0, 0);
    drv_div(0, 0, 0, 0);
    chk("full_div_ready", div_ready, 0);
    #2;
    resetn = 1'b0;
    #1;
    chk("async_rst_rf_we", rf_we, 0);
    chk("async_rst_dbg_we", debug_wb_rf_we, 0);
    chk("async_rst_div_ready", div_ready, 1);
    chk("async_rst_allowin", pipe_allowin, 1);
    tick(); tick();
    resetn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("post_rst_no_stale", rf_we, 0);
    end

    exp_w(cyc + 1, 5'd30, dat(5'd30), pcf(5'd30));
    drv_pipe(1, 1, 5'd30, dat(5'd30), pcf(5'd30));
    tick();
    drv_pipe(0, 0, 0, 0, 0);
    tick(); tick();

    chk("scoreboard_drained", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
